switch_debouncer: RTL and testbench

//   Conditions a raw mechanical switch or pushbutton input before it reaches the
//   lab's clocked storage elements.
//   - Synchronises the asynchronous input into the Clock domain.
//   - Rejects contact bounce.
//   - Drives a clean debounced level (Level), which feeds a flip-flop D input.
//   - Drives single-cycle edge pulses (Rise, Fall), which serve as clock-enables or step strobes.
//

---
 rtl/switch_debouncer.sv | 205 ++++++++++++++++++++
 tb/tb_switch_debouncer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions a raw mechanical switch input: synchronises it into the Clock
//   domain, rejects contact bounce with a stability counter, and produces a
//   registered debounced level together with one-cycle rise/fall strobes.
//   A small checker module at the end of this file carries the run-time
//   invariants of the qualifier and is instantiated by the top.

module switch_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 500000,
   parameter int CNT_WIDTH     = 20
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Raw,
   output logic Level,
   output logic Rise,
   output logic Fall,
   output logic Busy
);

   // Qualifier states: two settled levels and two "candidate change" states.
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      WAIT_HIGH = 2'b01,
      IDLE_HIGH = 2'b10,
      WAIT_LOW  = 2'b11
   } state_t;

   // Terminal count: the cycle on which a candidate level is accepted.
   localparam logic [CNT_WIDTH-1:0] COUNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] COUNT_ZERO = CNT_WIDTH'(0);
   localparam logic [CNT_WIDTH-1:0] COUNT_ONE  = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;

   state_t                 state_r;
   state_t                 state_s;
   logic [CNT_WIDTH-1:0]   count_r;
   logic [CNT_WIDTH-1:0]   count_s;
   logic                   level_r;
   logic                   level_s;
   logic                   rise_r;
   logic                   rise_s;
   logic                   fall_r;
   logic                   fall_s;

   // True while a candidate level change is being qualified.
   function automatic logic is_wait(input state_t st);
      logic w;
      case (st)
         WAIT_HIGH: w = 1'b1;
         WAIT_LOW:  w = 1'b1;
         default:   w = 1'b0;
      endcase
      return w;
   endfunction

   // Saturation-safe increment: the counter stops at the terminal count.
   function automatic logic [CNT_WIDTH-1:0] count_inc(input logic [CNT_WIDTH-1:0] c);
      logic [CNT_WIDTH-1:0] n;
      if (c == COUNT_LAST) begin
         n = c;
      end else begin
         n = c + COUNT_ONE;
      end
      return n;
   endfunction

   // Synchroniser chain: Raw enters at bit 0, the oldest sample is Sync.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], Raw};
      end
   end

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Next-state, counter and output decode for the bounce qualifier.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      level_s = level_r;
      rise_s  = 1'b0;
      fall_s  = 1'b0;
      case (state_r)
         IDLE_LOW: begin
            if (sync_s) begin
               state_s = WAIT_HIGH;
               count_s = COUNT_ZERO;
            end else begin
               state_s = IDLE_LOW;
            end
         end
         WAIT_HIGH: begin
            if (!sync_s) begin
               // Bounce: the input fell back before qualifying.
               state_s = IDLE_LOW;
               count_s = COUNT_ZERO;
            end else if (count_r == COUNT_LAST) begin
               state_s = IDLE_HIGH;
               count_s = COUNT_ZERO;
               level_s = 1'b1;
               rise_s  = 1'b1;
            end else begin
               count_s = count_inc(count_r);
            end
         end
         IDLE_HIGH: begin
            if (!sync_s) begin
               state_s = WAIT_LOW;
               count_s = COUNT_ZERO;
            end else begin
               state_s = IDLE_HIGH;
            end
         end
         WAIT_LOW: begin
            if (sync_s) begin
               // Bounce: the input rose back before qualifying.
               state_s = IDLE_HIGH;
               count_s = COUNT_ZERO;
            end else if (count_r == COUNT_LAST) begin
               state_s = IDLE_LOW;
               count_s = COUNT_ZERO;
               level_s = 1'b0;
               fall_s  = 1'b1;
            end else begin
               count_s = count_inc(count_r);
            end
         end
         default: begin
            state_s = IDLE_LOW;
            count_s = COUNT_ZERO;
            level_s = 1'b0;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE_LOW;
         count_r <= COUNT_ZERO;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         level_r <= level_s;
         rise_r  <= rise_s;
         fall_r  <= fall_s;
      end
   end

   assign Level = level_r;
   assign Rise  = rise_r;
   assign Fall  = fall_r;
   assign Busy  = is_wait(state_r);

   switch_debouncer_checker #(
      .CNT_WIDTH (CNT_WIDTH),
      .COUNT_LAST(COUNT_LAST)
   ) u_checker (
      .Clock(Clock),
      .Reset(Reset),
      .level(level_r),
      .rise (rise_r),
      .fall (fall_r),
      .count(count_r)
   );

endmodule

// switch_debouncer_checker
//   Run-time invariants of the debouncer: strobes are exclusive and agree with
//   the level they announce, and the stability counter stays in range.
module switch_debouncer_checker #(
   parameter int                   CNT_WIDTH  = 20,
   parameter logic [CNT_WIDTH-1:0] COUNT_LAST = '1
) (
   input logic                 Clock,
   input logic                 Reset,
   input logic                 level,
   input logic                 rise,
   input logic                 fall,
   input logic [CNT_WIDTH-1:0] count
);

   a_pulse_exclusive : assert property (@(posedge Clock) disable iff (Reset)
      !(rise && fall));

   a_rise_level : assert property (@(posedge Clock) disable iff (Reset)
      rise |-> level);

   a_fall_level : assert property (@(posedge Clock) disable iff (Reset)
      fall |-> !level);

   a_count_range : assert property (@(posedge Clock) disable iff (Reset)
      count <= COUNT_LAST);

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Directed scenarios followed by randomized run-length stimulus, checked
//   against a reference model that tracks how many consecutive synchronised
//   samples disagree with the accepted level.

module tb_switch_debouncer;

   localparam int SYNC_STAGES   = 2;
   localparam int STABLE_CYCLES = 4;
   localparam int CNT_WIDTH     = 3;

   logic clock = 1'b0;
   logic reset;
   logic raw;
   logic level;
   logic rise;
   logic fall;
   logic busy;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit   m_pipe[$];
   int   m_run;
   logic m_level;
   logic m_rise;
   logic m_fall;

   always #5 clock = ~clock;

   switch_debouncer #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
   ) dut (
      .Clock(clock),
      .Reset(reset),
      .Raw  (raw),
      .Level(level),
      .Rise (rise),
      .Fall (fall),
      .Busy (busy)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b time=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pipe.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
      m_run   = 0;
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
   endtask

   // A new level is accepted once STABLE_CYCLES+1 consecutive synchronised
   // samples disagree with the current level; any agreeing sample restarts it.
   task automatic model_edge();
      bit s;
      if (reset) begin
         model_reset();
      end else begin
         s = m_pipe.pop_front();
         m_pipe.push_back(raw);
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (s != m_level) begin
            m_run++;
            if (m_run == STABLE_CYCLES + 1) begin
               m_level = s;
               m_run   = 0;
               if (s) m_rise = 1'b1;
               else   m_fall = 1'b1;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".level"}, level, m_level);
      chk({tag, ".rise"},  rise,  m_rise);
      chk({tag, ".fall"},  fall,  m_fall);
      chk({tag, ".busy"},  busy,  (m_run != 0));
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      check_model(tag);
   endtask

   initial begin
      bit saw_busy;
      bit v;
      int len;

      // Reset state
      reset = 1'b0;
      raw   = 1'b0;
      model_reset();
      #2;
      reset = 1'b1;
      #1;
      chk("rst.level", level, 1'b0);
      chk("rst.rise",  rise,  1'b0);
      chk("rst.fall",  fall,  1'b0);
      chk("rst.busy",  busy,  1'b0);
      step("rst_hold");
      step("rst_hold");
      reset = 1'b0;
      repeat (3) step("idle_low");

      // Clean 0->1: busy after edges 3..6, level/rise at edge 7
      raw = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step("t2");
         chk($sformatf("t2.busy_e%0d", e),  busy,  (e >= 3 && e <= 6));
         chk($sformatf("t2.level_e%0d", e), level, (e >= 7));
         chk($sformatf("t2.rise_e%0d", e),  rise,  (e == 7));
         chk($sformatf("t2.fall_e%0d", e),  fall,  1'b0);
      end

      // Asynchronous reset with Level = 1
      reset = 1'b1;
      #1;
      model_reset();
      chk("t1.level", level, 1'b0);
      chk("t1.rise",  rise,  1'b0);
      chk("t1.fall",  fall,  1'b0);
      chk("t1.busy",  busy,  1'b0);
      step("t1_hold");
      raw = 1'b0;
      step("t1_hold");
      reset = 1'b0;
      repeat (3) step("t1_idle");

      // Short pulse: 3 cycles high, 10 low
      saw_busy = 1'b0;
      raw = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         if (e == 4) raw = 1'b0;
         step("t3");
         if (busy) saw_busy = 1'b1;
         chk($sformatf("t3.level_e%0d", e), level, 1'b0);
         chk($sformatf("t3.rise_e%0d", e),  rise,  1'b0);
      end
      chk("t3.busy_seen", saw_busy, 1'b1);
      chk("t3.busy_end",  busy,     1'b0);

      // Excursion of exactly STABLE_CYCLES samples is still rejected
      raw = 1'b1;
      repeat (STABLE_CYCLES) step("edge4");
      raw = 1'b0;
      repeat (8) step("edge4_low");
      chk("edge4.level", level, 1'b0);

      // Bring Level high again, then a clean 1->0
      raw = 1'b1;
      repeat (9) step("t4_pre");
      chk("t4_pre.level", level, 1'b1);
      raw = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step("t4");
         chk($sformatf("t4.level_e%0d", e), level, (e < 7));
         chk($sformatf("t4.fall_e%0d", e),  fall,  (e == 7));
         chk($sformatf("t4.rise_e%0d", e),  rise,  1'b0);
      end
      repeat (2) step("t4_post");

      // Reset during qualification, released with Raw still high
      raw = 1'b1;
      repeat (4) step("t5_pre");
      reset = 1'b1;
      #1;
      model_reset();
      chk("t5.rst_rise", rise, 1'b0);
      chk("t5.rst_busy", busy, 1'b0);
      repeat (2) begin
         step("t5_hold");
         chk("t5.hold_rise", rise, 1'b0);
      end
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step("t5");
         chk($sformatf("t5.rise_e%0d", e),  rise,  (e == 7));
         chk($sformatf("t5.level_e%0d", e), level, (e >= 7));
      end

      // Raw toggling every cycle
      for (int e = 1; e <= 50; e++) begin
         raw = ~raw;
         step("t6");
         chk("t6.level", level, 1'b1);
         chk("t6.rise",  rise,  1'b0);
         chk("t6.fall",  fall,  1'b0);
      end

      // Randomized run lengths around the qualification threshold
      for (int r = 0; r < 60; r++) begin
         v   = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 9));
         raw = v;
         repeat (len) step("rand");
      end
      repeat (10) step("drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
